trigger_sequencer: RTL and testbench

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/trigger_sequencer.sv | 133 +++++++++++++
 tb/tb_trigger_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer.sv
// Multi-channel trigger sequencer: a master rising edge launches per-channel
// delay / pulse / gap bursts, with busy tracking and overrun flagging.
module trigger_sequencer #(
    parameter int N_CHANNELS  = 4,
    parameter int COUNT_WIDTH = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                              ipClk,
    input  logic                              ipReset,
    input  logic                              ipMasterTrigger,
    input  logic [N_CHANNELS-1:0]             ipEnable,
    input  logic [N_CHANNELS*COUNT_WIDTH-1:0] ipDelay,
    input  logic [N_CHANNELS*COUNT_WIDTH-1:0] ipLength,
    input  logic [N_CHANNELS*COUNT_WIDTH-1:0] ipGap,
    input  logic [N_CHANNELS*BURST_WIDTH-1:0] ipBurst,
    output logic [N_CHANNELS-1:0]             opTrigger,
    output logic                              opBusy,
    output logic                              opOverrun
);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} chanState_t;

    chanState_t             state         [N_CHANNELS];
    chanState_t             stateNext     [N_CHANNELS];
    logic [COUNT_WIDTH-1:0] count         [N_CHANNELS];
    logic [COUNT_WIDTH-1:0] countNext     [N_CHANNELS];
    logic [COUNT_WIDTH-1:0] lenLatch      [N_CHANNELS];
    logic [COUNT_WIDTH-1:0] lenLatchNext  [N_CHANNELS];
    logic [COUNT_WIDTH-1:0] gapLatch      [N_CHANNELS];
    logic [COUNT_WIDTH-1:0] gapLatchNext  [N_CHANNELS];
    logic [BURST_WIDTH-1:0] burstLeft     [N_CHANNELS];
    logic [BURST_WIDTH-1:0] burstLeftNext [N_CHANNELS];

    logic                  prevTrigger;
    logic                  masterEdge;
    logic                  acceptEdge;
    logic [N_CHANNELS-1:0] triggerNext;
    logic [N_CHANNELS-1:0] activeNow;

    assign masterEdge = ipMasterTrigger & ~prevTrigger;
    assign acceptEdge = masterEdge & ~opBusy;

    // Counters hold the remaining cycles of the current phase and advance on reaching 1,
    // so an all-ones load gives exactly 2^W-1 cycles without wrapping.
    always_comb begin
        for (int k = 0; k < N_CHANNELS; k++) begin
            stateNext[k]     = state[k];
            countNext[k]     = count[k];
            lenLatchNext[k]  = lenLatch[k];
            gapLatchNext[k]  = gapLatch[k];
            burstLeftNext[k] = burstLeft[k];

            case (state[k])
                IDLE: begin
                    if (acceptEdge && ipEnable[k] &&
                        ipLength[k*COUNT_WIDTH +: COUNT_WIDTH] != '0) begin
                        lenLatchNext[k]  = ipLength[k*COUNT_WIDTH +: COUNT_WIDTH];
                        gapLatchNext[k]  = (ipGap[k*COUNT_WIDTH +: COUNT_WIDTH] == '0) ?
                                           COUNT_WIDTH'(1) : ipGap[k*COUNT_WIDTH +: COUNT_WIDTH];
                        burstLeftNext[k] = (ipBurst[k*BURST_WIDTH +: BURST_WIDTH] == '0) ?
                                           BURST_WIDTH'(1) : ipBurst[k*BURST_WIDTH +: BURST_WIDTH];
                        if (ipDelay[k*COUNT_WIDTH +: COUNT_WIDTH] == '0) begin
                            stateNext[k] = PULSE;
                            countNext[k] = ipLength[k*COUNT_WIDTH +: COUNT_WIDTH];
                        end else begin
                            stateNext[k] = DELAY;
                            countNext[k] = ipDelay[k*COUNT_WIDTH +: COUNT_WIDTH];
                        end
                    end
                end
                DELAY, GAP: begin
                    if (count[k] == COUNT_WIDTH'(1)) begin
                        stateNext[k] = PULSE;
                        countNext[k] = lenLatch[k];
                    end else begin
                        countNext[k] = count[k] - COUNT_WIDTH'(1);
                    end
                end
                PULSE: begin
                    if (count[k] != COUNT_WIDTH'(1)) begin
                        countNext[k] = count[k] - COUNT_WIDTH'(1);
                    end else if (burstLeft[k] == BURST_WIDTH'(1)) begin
                        stateNext[k]     = IDLE;
                        countNext[k]     = '0;
                        burstLeftNext[k] = '0;
                    end else begin
                        stateNext[k]     = GAP;
                        countNext[k]     = gapLatch[k];
                        burstLeftNext[k] = burstLeft[k] - BURST_WIDTH'(1);
                    end
                end
                default: begin
                    stateNext[k] = IDLE;
                    countNext[k] = '0;
                end
            endcase

            triggerNext[k] = (stateNext[k] == PULSE);
            activeNow[k]   = (state[k] != IDLE);
        end
    end

    // Busy includes the accepting edge so it rises the cycle after the edge and
    // trails the last channel's return to IDLE by one cycle.
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                state[k]     <= IDLE;
                count[k]     <= '0;
                lenLatch[k]  <= '0;
                gapLatch[k]  <= '0;
                burstLeft[k] <= '0;
            end
            prevTrigger <= 1'b1;
            opTrigger   <= '0;
            opBusy      <= 1'b0;
            opOverrun   <= 1'b0;
        end else begin
            for (int k = 0; k < N_CHANNELS; k++) begin
                state[k]     <= stateNext[k];
                count[k]     <= countNext[k];
                lenLatch[k]  <= lenLatchNext[k];
                gapLatch[k]  <= gapLatchNext[k];
                burstLeft[k] <= burstLeftNext[k];
            end
            prevTrigger <= ipMasterTrigger;
            opTrigger   <= triggerNext;
            opBusy      <= (|activeNow) | acceptEdge;
            opOverrun   <= masterEdge & opBusy;
        end
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: per-cycle vector table on a 4-channel
// instance plus hand-built burst sequences on a narrow-counter instance.
module tb_trigger_sequencer;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int BW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            master;
    logic [N-1:0]    en;
    logic [N*CW-1:0] dly, len, gap;
    logic [N*BW-1:0] bst;
    logic [N-1:0]    trig;
    logic            busy, ov;

    logic       sRst, sMaster;
    logic [0:0] sEn;
    logic [3:0] sDly, sLen, sGap;
    logic [1:0] sBst;
    logic [0:0] sTrig;
    logic       sBusy, sOv;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trigger_sequencer #(.N_CHANNELS(N), .COUNT_WIDTH(CW), .BURST_WIDTH(BW)) dut (
        .ipClk(clk), .ipReset(rst), .ipMasterTrigger(master), .ipEnable(en),
        .ipDelay(dly), .ipLength(len), .ipGap(gap), .ipBurst(bst),
        .opTrigger(trig), .opBusy(busy), .opOverrun(ov)
    );

    trigger_sequencer #(.N_CHANNELS(1), .COUNT_WIDTH(4), .BURST_WIDTH(2)) dutSmall (
        .ipClk(clk), .ipReset(sRst), .ipMasterTrigger(sMaster), .ipEnable(sEn),
        .ipDelay(sDly), .ipLength(sLen), .ipGap(sGap), .ipBurst(sBst),
        .opTrigger(sTrig), .opBusy(sBusy), .opOverrun(sOv)
    );

    typedef struct {
        logic       m;
        logic       r;
        logic       scr;
        logic [3:0] en;
        logic [3:0] eTrig;
        logic       eBusy;
        logic       eOv;
    } vec_t;

    vec_t vecs[$];

    function automatic void addRow(input logic m, input logic r, input logic scr,
                                   input logic [3:0] e, input logic [3:0] t,
                                   input logic b, input logic o);
        vec_t v;
        v.m = m; v.r = r; v.scr = scr; v.en = e; v.eTrig = t; v.eBusy = b; v.eOv = o;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic setCh(input int k, input int d, input int l, input int g, input int b);
        dly[k*CW +: CW] = CW'(d);
        len[k*CW +: CW] = CW'(l);
        gap[k*CW +: CW] = CW'(g);
        bst[k*BW +: BW] = BW'(b);
    endtask

    // ch0: single delayed pulse, ch1: 3-pulse burst, ch2: normally disabled, ch3: zero length
    task automatic applyNominal();
        setCh(0, 3, 2, 0, 1);
        setCh(1, 0, 1, 2, 3);
        setCh(2, 1, 1, 1, 1);
        setCh(3, 1, 0, 1, 1);
    endtask

    task automatic applyScramble();
        for (int k = 0; k < N; k++) setCh(k, 7, 5, 1, 2);
    endtask

    task automatic applyStimulus(input vec_t v);
        master = v.m;
        rst    = v.r;
        en     = v.en;
        if (v.scr) applyScramble();
        else       applyNominal();
    endtask

    // Narrow instance: edge at offset 0, compare trigger and busy against a burst model.
    task automatic runSmall(input int d, input int l, input int g, input int b, input string name);
        int  bEff, gEff, start, lastHigh;
        bit  expHigh[64];
        for (int i = 0; i < 64; i++) expHigh[i] = 1'b0;
        bEff  = (b == 0) ? 1 : b;
        gEff  = (g == 0) ? 1 : g;
        start = 1 + d;
        lastHigh = 0;
        for (int p = 0; p < bEff; p++) begin
            for (int c = start; c < start + l; c++) expHigh[c] = 1'b1;
            lastHigh = start + l - 1;
            start    = start + l + gEff;
        end
        sDly = 4'(d); sLen = 4'(l); sGap = 4'(g); sBst = 2'(b); sEn = 1'b1;
        sMaster = 1'b0;
        @(posedge clk); #1;
        for (int off = 0; off < lastHigh + 4; off++) begin
            sMaster = (off == 0);
            if (off == 2) begin
                sDly = 4'd1; sLen = 4'd1; sGap = 4'd1; sBst = 2'd1;
            end
            checkOutput({name, "_trig"}, off, 16'(sTrig), 16'(expHigh[off]));
            checkOutput({name, "_busy"}, off, 16'(sBusy),
                        16'((off >= 1) && (off <= lastHigh + 1)));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; master = 1'b1; en = '0;
        sRst = 1'b1; sMaster = 1'b0; sEn = 1'b0; sDly = '0; sLen = '0; sGap = '0; sBst = '0;
        applyNominal();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_trig", 0, 16'(trig), 16'h0);
        checkOutput("reset_busy", 0, 16'(busy), 16'h0);
        checkOutput("reset_ov",   0, 16'(ov),   16'h0);
        sRst = 1'b0;

        // held-high master across reset release must not start a sequence
        addRow(1, 0, 0, 4'b1011, 4'b0000, 0, 0);
        addRow(0, 0, 0, 4'b1011, 4'b0000, 0, 0);
        // A: ch0 + ch1 burst, ch2 disabled, ch3 zero length, second edge at T+3 dropped
        addRow(0, 0, 0, 4'b1011, 4'b0000, 0, 0);
        addRow(1, 0, 0, 4'b1011, 4'b0000, 0, 0);
        addRow(0, 0, 0, 4'b1011, 4'b0010, 1, 0);
        addRow(0, 0, 1, 4'b0100, 4'b0000, 1, 0);
        addRow(1, 0, 1, 4'b0100, 4'b0000, 1, 0);
        addRow(0, 0, 1, 4'b0100, 4'b0011, 1, 1);
        addRow(0, 0, 1, 4'b0100, 4'b0001, 1, 0);
        addRow(0, 0, 1, 4'b0100, 4'b0000, 1, 0);
        addRow(0, 0, 1, 4'b0100, 4'b0010, 1, 0);
        addRow(0, 0, 1, 4'b0100, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0000, 0, 0);
        // B: reset at T+4 with master held high, then a fresh edge
        addRow(1, 0, 0, 4'b0011, 4'b0000, 0, 0);
        addRow(1, 0, 0, 4'b0011, 4'b0010, 1, 0);
        addRow(1, 0, 0, 4'b0011, 4'b0000, 1, 0);
        addRow(1, 0, 0, 4'b0011, 4'b0000, 1, 0);
        addRow(1, 1, 0, 4'b0011, 4'b0011, 1, 0);
        addRow(1, 0, 0, 4'b0011, 4'b0000, 0, 0);
        addRow(1, 0, 0, 4'b0011, 4'b0000, 0, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0000, 0, 0);
        addRow(1, 0, 0, 4'b0011, 4'b0000, 0, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0010, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0011, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0001, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0010, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0011, 4'b0000, 0, 0);
        // C: edge on the cycle ch0 returns to IDLE is dropped and flagged
        addRow(1, 0, 0, 4'b0001, 4'b0000, 0, 0);
        addRow(0, 0, 0, 4'b0001, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0001, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0001, 4'b0000, 1, 0);
        addRow(0, 0, 0, 4'b0001, 4'b0001, 1, 0);
        addRow(0, 0, 0, 4'b0001, 4'b0001, 1, 0);
        addRow(1, 0, 0, 4'b0001, 4'b0000, 1, 0);
        addRow(1, 0, 0, 4'b0001, 4'b0000, 0, 1);
        addRow(1, 0, 0, 4'b0001, 4'b0000, 0, 0);
        addRow(0, 0, 0, 4'b0001, 4'b0000, 0, 0);

        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput("trig", i, 16'(trig), 16'(vecs[i].eTrig));
            checkOutput("busy", i, 16'(busy), 16'(vecs[i].eBusy));
            checkOutput("ovr",  i, 16'(ov),   16'(vecs[i].eOv));
            @(posedge clk); #1;
        end

        runSmall(15, 15, 0, 1, "maxDelayLen");
        runSmall(0, 1, 0, 3, "maxBurstGap0");
        runSmall(2, 3, 4, 0, "burstZero");
        runSmall(1, 2, 15, 2, "maxGap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
